// File: rtl/kv_pkg.sv
// Shared types and bus address map for the scanning key-value store.
package kv_pkg;

    typedef enum logic [2:0] {
        OP_INSERT,
        OP_LOOKUP,
        OP_DELETE,
        OP_DIRECT,
        OP_ILLEGAL
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_e;

    localparam int ADR_KEYED       = 0;
    localparam int ADR_DELETE      = 1;
    localparam int ADR_DIRECT_BASE = 2;

endpackage

// File: rtl/kv_slot_array.sv
// Key/value/valid storage: one write port, one indexed combinational read port.
module kv_slot_array #(
    parameter int KEY_W = 8,
    parameter int VAL_W = 8,
    parameter int DEPTH = 16,
    parameter int SW    = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             wr_en,
    input  logic [SW-1:0]    wr_idx,
    input  logic [KEY_W-1:0] wr_key,
    input  logic [VAL_W-1:0] wr_val,
    input  logic             wr_valid,
    input  logic [SW-1:0]    rd_idx,
    output logic             rd_valid,
    output logic [KEY_W-1:0] rd_key,
    output logic [VAL_W-1:0] rd_val
);

    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0][KEY_W-1:0] keys;
    logic [DEPTH-1:0][VAL_W-1:0] vals;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= wr_valid;
    end

    // Payload is meaningless while its valid bit is clear, so it carries no reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            keys[wr_idx] <= wr_key;
            vals[wr_idx] <= wr_val;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_key   = keys[rd_idx];
    assign rd_val   = vals[rd_idx];

endmodule

// File: rtl/kv_store_scan.sv
// Key-value store on a pipelined Wishbone-style slave; keyed ops scan one slot per cycle.
module kv_store_scan
    import kv_pkg::*;
#(
    parameter int KEY_W = 8,
    parameter int VAL_W = 8,
    parameter int DEPTH = 16,
    parameter int ADR_W = 8
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       CYC_i,
    input  logic                       STB_i,
    input  logic                       WE_i,
    input  logic [ADR_W-1:0]           ADR_i,
    input  logic [KEY_W-1:0]           KEY_i,
    input  logic [VAL_W-1:0]           DAT_i,
    output logic                       STALL_o,
    output logic                       ACK_o,
    output logic                       ERR_o,
    output logic [VAL_W-1:0]           DAT_o,
    output logic [$clog2(DEPTH+1)-1:0] COUNT_o,
    output logic                       FULL_o
);

    localparam int SW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        op_e              op;
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] dat;
    } req_t;

    state_e           state, state_nx;
    req_t             req;
    op_e              op_dec;
    logic             accept;
    logic [SW-1:0]    adr_slot;
    logic [SW-1:0]    scan_idx;
    logic             free_found;
    logic [SW-1:0]    free_idx;
    logic             free_now;
    logic [SW-1:0]    free_idx_now;
    logic             hit, last;
    logic [CW-1:0]    count, count_nx;
    logic             resp_go, resp_ack;
    logic [VAL_W-1:0] resp_dat;

    logic             rd_valid;
    logic [SW-1:0]    rd_idx;
    logic [KEY_W-1:0] rd_key;
    logic [VAL_W-1:0] rd_val;
    logic             wr_en, wr_valid;
    logic [SW-1:0]    wr_idx;
    logic [KEY_W-1:0] wr_key;
    logic [VAL_W-1:0] wr_val;

    kv_slot_array #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH), .SW(SW)) u_slots (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_key    (wr_key),
        .wr_val    (wr_val),
        .wr_valid  (wr_valid),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_key    (rd_key),
        .rd_val    (rd_val)
    );

    always_comb begin
        adr_slot = SW'(ADR_i - ADR_W'(ADR_DIRECT_BASE));
        op_dec   = OP_ILLEGAL;
        if (ADR_i == ADR_W'(ADR_KEYED))
            op_dec = WE_i ? OP_INSERT : OP_LOOKUP;
        else if (ADR_i == ADR_W'(ADR_DELETE))
            op_dec = WE_i ? OP_DELETE : OP_ILLEGAL;
        else if (ADR_i <= ADR_W'(DEPTH + 1))
            op_dec = OP_DIRECT;
    end

    assign accept  = (state == IDLE) && CYC_i && STB_i;
    assign STALL_o = (state != IDLE);
    assign COUNT_o = count;
    assign FULL_o  = (count == CW'(DEPTH));

    // The read port serves the direct slot while idle and the scan slot otherwise.
    assign rd_idx       = (state == IDLE) ? adr_slot : scan_idx;
    assign hit          = rd_valid && (rd_key == req.key);
    assign last         = (scan_idx == SW'(DEPTH - 1));
    assign free_now     = free_found || !rd_valid;
    assign free_idx_now = free_found ? free_idx : scan_idx;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        resp_go  = 1'b0;
        resp_ack = 1'b0;
        resp_dat = '0;
        count_nx = count;
        wr_en    = 1'b0;
        wr_idx   = rd_idx;
        wr_key   = rd_key;
        wr_val   = rd_val;
        wr_valid = rd_valid;
        unique case (state)
            IDLE: if (accept) begin
                if (op_dec == OP_DIRECT) begin
                    state_nx = RESP;
                    resp_go  = 1'b1;
                    if (rd_valid) begin
                        resp_ack = 1'b1;
                        resp_dat = WE_i ? DAT_i : rd_val;
                        wr_en    = WE_i;
                        wr_val   = DAT_i;
                    end
                end else if (op_dec == OP_ILLEGAL) begin
                    state_nx = RESP;
                    resp_go  = 1'b1;
                end else begin
                    state_nx = SCAN;
                end
            end
            SCAN: if (!CYC_i) begin
                state_nx = IDLE;
            end else if (hit || last) begin
                state_nx = RESP;
                resp_go  = 1'b1;
                case (req.op)
                    OP_INSERT: if (hit) begin
                        resp_ack = 1'b1;
                        resp_dat = VAL_W'(scan_idx);
                        wr_en    = 1'b1;
                        wr_val   = req.dat;
                    end else if (free_now) begin
                        resp_ack = 1'b1;
                        resp_dat = VAL_W'(free_idx_now);
                        wr_en    = 1'b1;
                        wr_idx   = free_idx_now;
                        wr_key   = req.key;
                        wr_val   = req.dat;
                        wr_valid = 1'b1;
                        count_nx = count + CW'(1);
                    end
                    OP_LOOKUP: if (hit) begin
                        resp_ack = 1'b1;
                        resp_dat = rd_val;
                    end
                    OP_DELETE: if (hit) begin
                        resp_ack = 1'b1;
                        resp_dat = VAL_W'(scan_idx);
                        wr_en    = 1'b1;
                        wr_valid = 1'b0;
                        count_nx = count - CW'(1);
                    end
                    default: ;
                endcase
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ACK_o      <= 1'b0;
            ERR_o      <= 1'b0;
            DAT_o      <= '0;
            count      <= '0;
            scan_idx   <= '0;
            free_found <= 1'b0;
            free_idx   <= '0;
        end else begin
            ACK_o <= resp_go && resp_ack;
            ERR_o <= resp_go && !resp_ack;
            count <= count_nx;
            if (resp_go)
                DAT_o <= resp_dat;
            if (accept) begin
                scan_idx   <= '0;
                free_found <= 1'b0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + SW'(1);
                if (!free_found && !rd_valid) begin
                    free_found <= 1'b1;
                    free_idx   <= scan_idx;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept)
            req <= '{op: op_dec, key: KEY_i, dat: DAT_i};
    end

endmodule

// File: tb/tb_kv_store_scan.sv
// Randomised and directed checks of kv_store_scan against a slot-level reference model.
module tb_kv_store_scan;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          CYC_i = 1'b0, STB_i = 1'b0, WE_i = 1'b0;
    logic [7:0]    ADR_i = '0, KEY_i = '0, DAT_i = '0;
    logic          STALL_o, ACK_o, ERR_o, FULL_o;
    logic [7:0]    DAT_o;
    logic [CW-1:0] COUNT_o;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] mk [DEPTH];
    logic [7:0] mv [DEPTH];
    bit         mval [DEPTH];

    kv_store_scan #(.KEY_W(8), .VAL_W(8), .DEPTH(DEPTH), .ADR_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .CYC_i(CYC_i), .STB_i(STB_i), .WE_i(WE_i),
        .ADR_i(ADR_i), .KEY_i(KEY_i), .DAT_i(DAT_i), .STALL_o(STALL_o), .ACK_o(ACK_o),
        .ERR_o(ERR_o), .DAT_o(DAT_o), .COUNT_o(COUNT_o), .FULL_o(FULL_o)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout: got running want finished");
        $fatal(1);
    end

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += mval[i] ? 1 : 0;
        return c;
    endfunction

    // Reference behaviour: returns expected ACK, response cycle, and DAT_o when defined.
    task automatic model_step(input logic [7:0] adr, input logic we, input logic [7:0] key,
                              input logic [7:0] dat, output logic ea, output int el,
                              output logic [7:0] ed, output logic edc);
        int hit = -1, free = -1, s;
        ea = 1'b0; el = 1; ed = '0; edc = 1'b0;
        if (adr == 0 || (adr == 1 && we)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (mval[i] && mk[i] == key) hit = i;
                if (!mval[i]) free = i;
            end
            el = (hit >= 0) ? hit + 2 : DEPTH + 1;
            if (adr == 0 && we) begin
                if (hit >= 0) begin
                    mv[hit] = dat; ea = 1'b1; ed = 8'(hit); edc = 1'b1;
                end else if (free >= 0) begin
                    mk[free] = key; mv[free] = dat; mval[free] = 1'b1;
                    ea = 1'b1; ed = 8'(free); edc = 1'b1;
                end
            end else if (adr == 0) begin
                edc = 1'b1;
                if (hit >= 0) begin ea = 1'b1; ed = mv[hit]; end
            end else if (hit >= 0) begin
                mval[hit] = 1'b0; ea = 1'b1; ed = 8'(hit); edc = 1'b1;
            end
        end else if (adr >= 2 && adr <= DEPTH + 1) begin
            s = adr - 2;
            if (mval[s]) begin
                ea = 1'b1; edc = 1'b1;
                if (we) mv[s] = dat;
                ed = mv[s];
            end else begin
                edc = !we;
            end
        end
    endtask

    // Drives one request and reports the first response and the cycle after it.
    task automatic issue(input logic [7:0] adr, input logic we, input logic [7:0] key,
                         input logic [7:0] dat, output int lat, output logic a,
                         output logic e, output logic [7:0] d, output logic st1,
                         output logic post_pulse, output logic post_stall);
        @(negedge sys_clk);
        CYC_i = 1'b1; STB_i = 1'b1; WE_i = we; ADR_i = adr; KEY_i = key; DAT_i = dat;
        lat = 0; a = 1'b0; e = 1'b0; d = '0; st1 = 1'b0;
        for (int n = 1; n <= DEPTH + 4; n++) begin
            @(negedge sys_clk);
            if (n == 1) st1 = STALL_o;
            if (ACK_o || ERR_o) begin
                lat = n; a = ACK_o; e = ERR_o; d = DAT_o;
                break;
            end
        end
        CYC_i = 1'b0; STB_i = 1'b0;
        @(negedge sys_clk);
        post_pulse = ACK_o | ERR_o;
        post_stall = STALL_o;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0; CYC_i = 1'b0; STB_i = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic a, e, st1, pp, ps; logic [7:0] d;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp++; if ({STALL_o, ACK_o, ERR_o, FULL_o} !== 4'b0) begin n_fail++;
            $display("FAIL rst_flags got %b want 0000", {STALL_o, ACK_o, ERR_o, FULL_o}); end
        n_cmp++; if (DAT_o !== 8'h00 || COUNT_o !== '0) begin n_fail++;
            $display("FAIL rst_dat_cnt got dat=%h cnt=%0d want 0/0", DAT_o, COUNT_o); end
        sys_rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;
        issue(8'd0, 1'b0, 8'h11, 8'h00, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (e !== 1'b1 || a !== 1'b0 || lat != DEPTH + 1) begin n_fail++;
            $display("FAIL empty_lookup got ack=%b err=%b lat=%0d want err at %0d", a, e, lat, DEPTH + 1); end
        n_cmp++; if (d !== 8'h00 || COUNT_o !== '0) begin n_fail++;
            $display("FAIL empty_lookup_dat got dat=%h cnt=%0d want 0/0", d, COUNT_o); end
        n_cmp++; if (st1 !== 1'b1 || ps !== 1'b0 || pp !== 1'b0) begin n_fail++;
            $display("FAIL stall_window got st1=%b post_stall=%b post_pulse=%b want 1/0/0", st1, ps, pp); end
    endtask

    task automatic test_insert_lookup();
        int lat, el; logic a, e, st1, pp, ps, ea, edc; logic [7:0] d, ed;
        model_step(8'd0, 1'b1, 8'h11, 8'hA5, ea, el, ed, edc);
        issue(8'd0, 1'b1, 8'h11, 8'hA5, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (a !== 1'b1 || d !== 8'h00 || lat != DEPTH + 1) begin n_fail++;
            $display("FAIL ins_new got ack=%b dat=%h lat=%0d want 1/00/%0d", a, d, lat, DEPTH + 1); end
        model_step(8'd0, 1'b0, 8'h11, 8'h00, ea, el, ed, edc);
        issue(8'd0, 1'b0, 8'h11, 8'h00, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (a !== 1'b1 || d !== 8'hA5 || lat != 2) begin n_fail++;
            $display("FAIL lookup_hit got ack=%b dat=%h lat=%0d want 1/a5/2", a, d, lat); end
        model_step(8'd0, 1'b1, 8'h11, 8'h3C, ea, el, ed, edc);
        issue(8'd0, 1'b1, 8'h11, 8'h3C, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (a !== 1'b1 || d !== 8'h00 || lat != 2 || COUNT_o !== CW'(1)) begin n_fail++;
            $display("FAIL ins_update got ack=%b dat=%h lat=%0d cnt=%0d want 1/00/2/1", a, d, lat, COUNT_o); end
        model_step(8'd2, 1'b0, 8'h00, 8'h00, ea, el, ed, edc);
        issue(8'd2, 1'b0, 8'h00, 8'h00, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (a !== 1'b1 || d !== 8'h3C || lat != 1) begin n_fail++;
            $display("FAIL direct_rd got ack=%b dat=%h lat=%0d want 1/3c/1", a, d, lat); end
    endtask

    task automatic test_random();
        int lat, el, sel; logic a, e, st1, pp, ps, ea, edc, we; logic [7:0] d, ed, adr, key, dat;
        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 7));
            key = 8'h20 + 8'($urandom_range(0, 19));
            dat = 8'($urandom);
            we = 1'b0; adr = 8'd0;
            case (sel)
                0, 1, 2: begin adr = 8'd0; we = 1'b1; end
                3:       begin adr = 8'd0; we = 1'b0; end
                4:       begin adr = 8'd1; we = 1'b1; end
                5:       begin adr = 8'd2 + 8'($urandom_range(0, DEPTH - 1)); we = 1'b0; end
                6:       begin adr = 8'd2 + 8'($urandom_range(0, DEPTH - 1)); we = 1'b1; end
                default: begin
                    if ($urandom_range(0, 1) == 0) adr = 8'd1;
                    else begin adr = 8'($urandom_range(DEPTH + 2, 255)); we = 1'($urandom_range(0, 1)); end
                end
            endcase
            model_step(adr, we, key, dat, ea, el, ed, edc);
            issue(adr, we, key, dat, lat, a, e, d, st1, pp, ps);
            n_cmp++; if (a !== ea || e !== !ea) begin n_fail++;
                $display("FAIL rnd_resp t=%0d adr=%0d we=%b key=%h got ack=%b err=%b want ack=%b", t, adr, we, key, a, e, ea); end
            n_cmp++; if (lat != el) begin n_fail++;
                $display("FAIL rnd_lat t=%0d adr=%0d key=%h got %0d want %0d", t, adr, key, lat, el); end
            if (edc) begin
                n_cmp++; if (d !== ed) begin n_fail++;
                    $display("FAIL rnd_dat t=%0d adr=%0d key=%h got %h want %h", t, adr, key, d, ed); end
            end
            n_cmp++; if (COUNT_o !== CW'(model_count()) || FULL_o !== (model_count() == DEPTH)) begin n_fail++;
                $display("FAIL rnd_count t=%0d got cnt=%0d full=%b want %0d", t, COUNT_o, FULL_o, model_count()); end
            n_cmp++; if (pp !== 1'b0 || ps !== 1'b0 || st1 !== 1'b1) begin n_fail++;
                $display("FAIL rnd_handshake t=%0d got pulse=%b stall=%b st1=%b want 0/0/1", t, pp, ps, st1); end
        end
    endtask

    task automatic test_fill();
        int lat; logic a, e, st1, pp, ps; logic [7:0] d;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            issue(8'd0, 1'b1, 8'h40 + 8'(i), 8'h80 + 8'(i), lat, a, e, d, st1, pp, ps);
            n_cmp++; if (a !== 1'b1 || d !== 8'(i) || lat != DEPTH + 1) begin n_fail++;
                $display("FAIL fill_%0d got ack=%b dat=%h lat=%0d want 1/%h/%0d", i, a, d, lat, 8'(i), DEPTH + 1); end
        end
        n_cmp++; if (FULL_o !== 1'b1 || COUNT_o !== CW'(DEPTH)) begin n_fail++;
            $display("FAIL full_flag got full=%b cnt=%0d want 1/%0d", FULL_o, COUNT_o, DEPTH); end
        issue(8'd0, 1'b1, 8'h70, 8'h55, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (e !== 1'b1 || a !== 1'b0 || lat != DEPTH + 1 || COUNT_o !== CW'(DEPTH)) begin n_fail++;
            $display("FAIL ins_full got err=%b ack=%b lat=%0d cnt=%0d want 1/0/%0d/%0d", e, a, lat, COUNT_o, DEPTH + 1, DEPTH); end
        issue(8'd1, 1'b1, 8'h45, 8'h00, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (a !== 1'b1 || d !== 8'h05 || lat != 7 || COUNT_o !== CW'(DEPTH - 1) || FULL_o !== 1'b0) begin n_fail++;
            $display("FAIL delete5 got ack=%b dat=%h lat=%0d cnt=%0d full=%b want 1/05/7/%0d/0", a, d, lat, COUNT_o, FULL_o, DEPTH - 1); end
        issue(8'd0, 1'b1, 8'h60, 8'h99, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (a !== 1'b1 || d !== 8'h05 || lat != DEPTH + 1 || COUNT_o !== CW'(DEPTH)) begin n_fail++;
            $display("FAIL reuse5 got ack=%b dat=%h lat=%0d cnt=%0d want 1/05/%0d/%0d", a, d, lat, COUNT_o, DEPTH + 1, DEPTH); end
    endtask

    task automatic test_abort();
        int lat; logic a, e, st1, pp, ps, seen, st4; logic [7:0] d;
        seen = 1'b0; st4 = 1'b1;
        @(negedge sys_clk);
        CYC_i = 1'b1; STB_i = 1'b1; WE_i = 1'b1; ADR_i = 8'd0; KEY_i = 8'h4A; DAT_i = 8'hEE;
        for (int n = 1; n <= DEPTH + 3; n++) begin
            @(negedge sys_clk);
            STB_i = 1'b0;
            seen = seen | ACK_o | ERR_o;
            if (n == 3) CYC_i = 1'b0;
            if (n == 4) st4 = STALL_o;
        end
        n_cmp++; if (seen !== 1'b0 || st4 !== 1'b0) begin n_fail++;
            $display("FAIL abort got pulse=%b stall4=%b want 0/0", seen, st4); end
        issue(8'd0, 1'b0, 8'h4A, 8'h00, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (a !== 1'b1 || d !== 8'h8A || lat != 12 || COUNT_o !== CW'(DEPTH)) begin n_fail++;
            $display("FAIL abort_unchanged got ack=%b dat=%h lat=%0d cnt=%0d want 1/8a/12/%0d", a, d, lat, COUNT_o, DEPTH); end
    endtask

    task automatic test_reset_mid();
        int lat; logic a, e, st1, pp, ps, seen; logic [7:0] d;
        seen = 1'b0;
        @(negedge sys_clk);
        CYC_i = 1'b1; STB_i = 1'b1; WE_i = 1'b0; ADR_i = 8'd0; KEY_i = 8'h4F;
        for (int n = 1; n <= DEPTH + 4; n++) begin
            @(negedge sys_clk);
            STB_i = 1'b0;
            seen = seen | ACK_o | ERR_o;
            if (n == 5) begin sys_rst_n = 1'b0; CYC_i = 1'b0; end
            if (n == 7) sys_rst_n = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;
        n_cmp++; if (seen !== 1'b0 || COUNT_o !== '0 || STALL_o !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid got pulse=%b cnt=%0d stall=%b want 0/0/0", seen, COUNT_o, STALL_o); end
        issue(8'd0, 1'b0, 8'h4F, 8'h00, lat, a, e, d, st1, pp, ps);
        n_cmp++; if (e !== 1'b1 || a !== 1'b0 || lat != DEPTH + 1 || d !== 8'h00) begin n_fail++;
            $display("FAIL rst_mid_lookup got err=%b ack=%b lat=%0d dat=%h want 1/0/%0d/00", e, a, lat, d, DEPTH + 1); end
    endtask

    initial begin
        test_reset();
        test_insert_lookup();
        test_random();
        test_fill();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
